// File: rtl/du_host_link_if.sv
// du_host_link_if: byte/word handshake bundle between the host link, the
// instruction ROM, the UART core and the dump consumers.
//   i_load/i_run/i_mode/i_n_instr : command inputs
//   o_rom_addr/i_rom_data         : instruction ROM read port (1-clock latency)
//   o_tx_*/i_tx_done              : UART transmit byte handshake
//   i_rx_byte/i_rx_done           : UART receive byte handshake
//   o_pc/o_cycles/o_reg_*/o_mem_* : captured dump contents
//   o_busy/o_done/o_error/o_state : status
// slave = the host link itself, master = whatever drives it.
interface du_host_link_if #(
  parameter int NB_DATA     = 32,
  parameter int N_BITS      = 8,
  parameter int NB_ROM_ADDR = 7,
  parameter int NB_REG      = 5,
  parameter int NB_STATE    = 4
) ();
  logic                   i_load;
  logic                   i_run;
  logic [N_BITS-1:0]      i_mode;
  logic [N_BITS-1:0]      i_n_instr;
  logic [NB_ROM_ADDR-1:0] o_rom_addr;
  logic [NB_DATA-1:0]     i_rom_data;
  logic [N_BITS-1:0]      o_tx_byte;
  logic                   o_tx_start;
  logic                   i_tx_done;
  logic [N_BITS-1:0]      i_rx_byte;
  logic                   i_rx_done;
  logic [N_BITS-1:0]      o_pc;
  logic [N_BITS-1:0]      o_cycles;
  logic                   o_reg_we;
  logic [NB_REG-1:0]      o_reg_addr;
  logic [NB_DATA-1:0]     o_reg_data;
  logic                   o_mem_we;
  logic [N_BITS-1:0]      o_mem_addr;
  logic [NB_DATA-1:0]     o_mem_data;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_error;
  logic [NB_STATE-1:0]    o_state;

  modport slave (
    input  i_load, i_run, i_mode, i_n_instr, i_rom_data, i_tx_done, i_rx_byte, i_rx_done,
    output o_rom_addr, o_tx_byte, o_tx_start, o_pc, o_cycles, o_reg_we, o_reg_addr,
           o_reg_data, o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_error, o_state
  );

  modport master (
    output i_load, i_run, i_mode, i_n_instr, i_rom_data, i_tx_done, i_rx_byte, i_rx_done,
    input  o_rom_addr, o_tx_byte, o_tx_start, o_pc, o_cycles, o_reg_we, o_reg_addr,
           o_reg_data, o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_error, o_state
  );
endinterface

// File: rtl/du_host_link.sv
// du_host_link: host-side peer of the pipeline debug unit byte protocol.
// Sends count / instruction words (LSB byte first) / mode byte over a UART
// byte handshake, then collects PC, cycle count, 32 registers and dirty-memory
// records until the line stays idle for TIMEOUT clocks.
// Ports: i_clock, i_reset (sync, active low), bus (du_host_link_if.slave).
module du_host_link #(
  parameter int NB_DATA     = 32,
  parameter int N_BITS      = 8,
  parameter int N_BYTES     = 4,
  parameter int NB_ROM_ADDR = 7,
  parameter int NB_REG      = 5,
  parameter int N_REGS      = 32,
  parameter int TIMEOUT     = 100000,
  parameter int NB_TIMEOUT  = 17,
  parameter int NB_STATE    = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  du_host_link_if.slave bus
);
  localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_BIDX-1:0]    LAST_BYTE = NB_BIDX'(N_BYTES - 1);
  localparam logic [NB_REG-1:0]     LAST_REG  = NB_REG'(N_REGS - 1);
  localparam logic [NB_TIMEOUT-1:0] TMO_LAST  = NB_TIMEOUT'(TIMEOUT - 1);
  localparam logic [NB_TIMEOUT-1:0] TMO_MAX   = NB_TIMEOUT'(TIMEOUT);
  localparam logic [N_BITS-1:0]     MODE_STEP = N_BITS'(4);
  localparam logic [N_BITS-1:0]     MODE_CONT = N_BITS'(16);

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE        = NB_STATE'(0),
    ST_READY       = NB_STATE'(1),
    ST_SEND_COUNT  = NB_STATE'(2),
    ST_FETCH       = NB_STATE'(3),
    ST_SEND_INSTR  = NB_STATE'(4),
    ST_SEND_MODE   = NB_STATE'(5),
    ST_RX_PC       = NB_STATE'(6),
    ST_RX_CYCLES   = NB_STATE'(7),
    ST_RX_REG      = NB_STATE'(8),
    ST_RX_MEM_ADDR = NB_STATE'(9),
    ST_RX_MEM_DATA = NB_STATE'(10)
  } state_t;

  state_t                 state_q, state_d;
  logic [N_BITS-1:0]      n_instr_q, n_instr_d, mode_q, mode_d, instr_cnt_q, instr_cnt_d;
  logic [NB_ROM_ADDR-1:0] rom_addr_q, rom_addr_d;
  logic [NB_DATA-1:0]     word_q, word_d;
  logic [NB_BIDX-1:0]     byte_idx_q, byte_idx_d;
  logic                   fetch_wait_q, fetch_wait_d, tx_pend_q, tx_pend_d;
  logic                   tx_start_q, tx_start_d, programmed_q, programmed_d;
  logic [N_BITS-1:0]      tx_byte_q, tx_byte_d;
  logic [NB_TIMEOUT-1:0]  timeout_q, timeout_d;
  logic [N_BITS-1:0]      pc_q, pc_d, cycles_q, cycles_d, mem_addr_q, mem_addr_d;
  logic                   reg_we_q, reg_we_d, mem_we_q, mem_we_d, done_q, done_d, error_q, error_d;
  logic [NB_REG-1:0]      reg_addr_q, reg_addr_d;
  logic [NB_DATA-1:0]     reg_data_q, reg_data_d, mem_data_q, mem_data_d;

  logic              mode_ok, rx_state, byte_sent;
  logic [N_BITS-1:0] cur_byte;

  // State register (and the datapath registers it steers).
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;       n_instr_q <= '0;    mode_q <= '0;       instr_cnt_q <= '0;
      rom_addr_q <= '0;         word_q <= '0;       byte_idx_q <= '0;   fetch_wait_q <= 1'b0;
      tx_pend_q <= 1'b0;        tx_start_q <= 1'b0; tx_byte_q <= '0;    programmed_q <= 1'b0;
      timeout_q <= '0;          pc_q <= '0;         cycles_q <= '0;     mem_addr_q <= '0;
      reg_we_q <= 1'b0;         mem_we_q <= 1'b0;   done_q <= 1'b0;     error_q <= 1'b0;
      reg_addr_q <= '0;         reg_data_q <= '0;   mem_data_q <= '0;
    end else begin
      state_q <= state_d;       n_instr_q <= n_instr_d; mode_q <= mode_d; instr_cnt_q <= instr_cnt_d;
      rom_addr_q <= rom_addr_d; word_q <= word_d;   byte_idx_q <= byte_idx_d; fetch_wait_q <= fetch_wait_d;
      tx_pend_q <= tx_pend_d;   tx_start_q <= tx_start_d; tx_byte_q <= tx_byte_d; programmed_q <= programmed_d;
      timeout_q <= timeout_d;   pc_q <= pc_d;       cycles_q <= cycles_d; mem_addr_q <= mem_addr_d;
      reg_we_q <= reg_we_d;     mem_we_q <= mem_we_d; done_q <= done_d; error_q <= error_d;
      reg_addr_q <= reg_addr_d; reg_data_q <= reg_data_d; mem_data_q <= mem_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;         n_instr_d = n_instr_q;   mode_d = mode_q;     instr_cnt_d = instr_cnt_q;
    rom_addr_d = rom_addr_q;   word_d = word_q;         byte_idx_d = byte_idx_q;
    fetch_wait_d = fetch_wait_q; tx_pend_d = tx_pend_q; tx_byte_d = tx_byte_q;
    programmed_d = programmed_q; timeout_d = timeout_q; pc_d = pc_q;         cycles_d = cycles_q;
    mem_addr_d = mem_addr_q;   reg_addr_d = reg_addr_q; reg_data_d = reg_data_q; mem_data_d = mem_data_q;
    tx_start_d = 1'b0; reg_we_d = 1'b0; mem_we_d = 1'b0; done_d = 1'b0; error_d = 1'b0;
    byte_sent = 1'b0;

    mode_ok  = (bus.i_mode == MODE_STEP) || (bus.i_mode == MODE_CONT);
    rx_state = state_q inside {ST_RX_PC, ST_RX_CYCLES, ST_RX_REG, ST_RX_MEM_ADDR, ST_RX_MEM_DATA};

    case (state_q)
      ST_SEND_COUNT: cur_byte = n_instr_q;
      ST_SEND_MODE:  cur_byte = mode_q;
      default:       cur_byte = word_q[int'(byte_idx_q)*N_BITS +: N_BITS];
    endcase

    // The register index advances while o_reg_we is high, so addr/data are
    // valid together during the pulse.
    if (reg_we_q) reg_addr_d = (reg_addr_q == LAST_REG) ? '0 : reg_addr_q + NB_REG'(1);

    if (rx_state) begin
      if (bus.i_rx_done)          timeout_d = '0;
      else if (timeout_q != TMO_MAX) timeout_d = timeout_q + NB_TIMEOUT'(1);
    end

    // Shared byte transmitter for all SEND_* states: one start per byte,
    // byte held until its done tick.
    if (state_q inside {ST_SEND_COUNT, ST_SEND_INSTR, ST_SEND_MODE}) begin
      if (!tx_pend_q) begin
        tx_start_d = 1'b1;
        tx_pend_d  = 1'b1;
        tx_byte_d  = cur_byte;
      end else if (bus.i_tx_done) begin
        tx_pend_d = 1'b0;
        byte_sent = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (bus.i_load) begin
          if (mode_ok && (bus.i_n_instr != '0)) begin
            n_instr_d = bus.i_n_instr; mode_d = bus.i_mode;
            instr_cnt_d = '0; rom_addr_d = '0; byte_idx_d = '0;
            state_d = ST_SEND_COUNT;
          end else error_d = 1'b1;
        end else if (bus.i_run) begin
          if (state_q == ST_READY && programmed_q && mode_ok) begin
            mode_d = bus.i_mode;
            state_d = ST_SEND_MODE;
          end else error_d = 1'b1;
        end
      end
      ST_SEND_COUNT: if (byte_sent) begin
        fetch_wait_d = 1'b1;
        state_d = ST_FETCH;
      end
      // First cycle lets the ROM register the new address; second latches.
      ST_FETCH: begin
        if (fetch_wait_q) fetch_wait_d = 1'b0;
        else begin
          word_d = bus.i_rom_data; byte_idx_d = '0;
          state_d = ST_SEND_INSTR;
        end
      end
      ST_SEND_INSTR: if (byte_sent) begin
        byte_idx_d = byte_idx_q + NB_BIDX'(1);
        if (byte_idx_q == LAST_BYTE) begin
          if (instr_cnt_q == n_instr_q - N_BITS'(1)) state_d = ST_SEND_MODE;
          else begin
            instr_cnt_d = instr_cnt_q + N_BITS'(1);
            rom_addr_d = rom_addr_q + NB_ROM_ADDR'(1);
            fetch_wait_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_SEND_MODE: if (byte_sent) begin
        programmed_d = 1'b1; timeout_d = '0; reg_addr_d = '0; byte_idx_d = '0;
        state_d = ST_RX_PC;
      end
      ST_RX_PC: if (bus.i_rx_done) begin
        pc_d = bus.i_rx_byte; state_d = ST_RX_CYCLES;
      end
      ST_RX_CYCLES: if (bus.i_rx_done) begin
        cycles_d = bus.i_rx_byte; byte_idx_d = '0; state_d = ST_RX_REG;
      end
      ST_RX_REG: if (bus.i_rx_done) begin
        reg_data_d[int'(byte_idx_q)*N_BITS +: N_BITS] = bus.i_rx_byte;
        byte_idx_d = byte_idx_q + NB_BIDX'(1);
        if (byte_idx_q == LAST_BYTE) begin
          reg_we_d = 1'b1;
          if (reg_addr_q == LAST_REG) state_d = ST_RX_MEM_ADDR;
        end
      end
      ST_RX_MEM_ADDR: if (bus.i_rx_done) begin
        mem_addr_d = bus.i_rx_byte; byte_idx_d = '0; state_d = ST_RX_MEM_DATA;
      end
      ST_RX_MEM_DATA: if (bus.i_rx_done) begin
        mem_data_d[int'(byte_idx_q)*N_BITS +: N_BITS] = bus.i_rx_byte;
        byte_idx_d = byte_idx_q + NB_BIDX'(1);
        if (byte_idx_q == LAST_BYTE) begin
          mem_we_d = 1'b1; state_d = ST_RX_MEM_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle line: clean end only between memory records, abort otherwise.
    if (rx_state && !bus.i_rx_done && timeout_q == TMO_LAST) begin
      if (state_q == ST_RX_MEM_ADDR) done_d = 1'b1;
      else                           error_d = 1'b1;
      timeout_d = '0; byte_idx_d = '0;
      state_d = ST_READY;
    end
  end

  // Outputs.
  always_comb begin
    bus.o_busy  = !(state_q == ST_IDLE || state_q == ST_READY);
    bus.o_state = state_q;
  end

  assign bus.o_rom_addr = rom_addr_q;
  assign bus.o_tx_byte  = tx_byte_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_cycles   = cycles_q;
  assign bus.o_reg_we   = reg_we_q;
  assign bus.o_reg_addr = reg_addr_q;
  assign bus.o_reg_data = reg_data_q;
  assign bus.o_mem_we   = mem_we_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_done     = done_q;
  assign bus.o_error    = error_q;
endmodule

// File: doc/du_host_link.md
Name: du_host_link

Overview:
- Host-side peer of the pipeline debug unit's UART byte protocol.
- Sends the program frame: instruction count, instruction words, then the operation-mode byte.
- Collects the returned dump: PC, cycle count, 32 registers, and dirty-memory records.
- Sits between an instruction ROM and a UART core (byte-level tx/rx handshakes). Used for on-board self-test and loopback boot of the MIPS pipeline.

Parameters:
- NB_DATA, 32, instruction/register/memory word width.
- N_BITS, 8, UART byte width.
- N_BYTES, 4, bytes per word.
- NB_ROM_ADDR, 7, instruction ROM address width.
- NB_REG, 5, register index width.
- N_REGS, 32, registers in a dump.
- TIMEOUT, 100000, idle clocks that end/abort reception.
- NB_TIMEOUT, 17, timeout counter width.
- NB_STATE, 4, state encoding width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_load  in  1  pulse: send full program frame.
- i_run  in  1  pulse: send mode byte only (program already loaded).
- i_mode  in  N_BITS  operation mode; 8'd4 = step, 8'd16 = continue.
- i_n_instr  in  N_BITS  number of instructions to send.
- o_rom_addr  out  NB_ROM_ADDR  ROM read address.
- i_rom_data  in  NB_DATA  ROM word, valid 1 clock after address.
- o_tx_byte  out  N_BITS  byte to UART tx.
- o_tx_start  out  1  1-clock start pulse.
- i_tx_done  in  1  UART byte-sent tick.
- i_rx_byte  in  N_BITS  received byte.
- i_rx_done  in  1  UART byte-received tick.
- o_pc  out  N_BITS  captured PC byte.
- o_cycles  out  N_BITS  captured cycle-count byte.
- o_reg_we  out  1  1-clock pulse: o_reg_addr/o_reg_data valid.
- o_reg_addr  out  NB_REG  register index.
- o_reg_data  out  NB_DATA  register value.
- o_mem_we  out  1  1-clock pulse: memory record valid.
- o_mem_addr  out  N_BITS  dirty memory address.
- o_mem_data  out  NB_DATA  memory word.
- o_busy  out  1  frame in progress.
- o_done  out  1  1-clock pulse: dump complete.
- o_error  out  1  1-clock pulse: rejected command or aborted dump.
- o_state  out  NB_STATE  current state (debug).

Behaviour:
- Reset (i_reset low at posedge):
  - State becomes IDLE; every output is 0.
  - The "programmed" flag clears.
  - A reset in any state aborts immediately; no partial tx/rx completion is reported.
- Command validation:
  - i_load is accepted in IDLE or READY.
  - i_run is accepted only in READY.
  - i_mode other than 4/16, or i_n_instr == 0 on i_load, gives an o_error pulse and no state change.
  - i_load and i_run in the same clock: i_load wins.
- TX handshake:
  - One o_tx_start pulse per byte; o_tx_byte is held stable until i_tx_done.
  - The next byte's start is no earlier than 1 clock after i_tx_done.
- Words are sent and received LSB byte first: byte k maps to bits [8k+7:8k].
- States:
  - IDLE/READY: wait for a command; o_busy = 0. In READY, i_load re-programs and i_run sends SEND_MODE.
  - SEND_COUNT: send i_n_instr (latched at command), then FETCH with o_rom_addr = 0.
  - FETCH: wait 1 clock for ROM data, latch the word, go to SEND_INSTR.
  - SEND_INSTR: send 4 bytes. Then, if o_rom_addr == n_instr-1, go to SEND_MODE; else increment o_rom_addr (wrapping at 2^NB_ROM_ADDR) and go to FETCH.
  - SEND_MODE: send the latched mode byte, set programmed, clear the timeout counter, go to RX_PC.
  - RX_PC and RX_CYCLES: the first and second received bytes go to o_pc and o_cycles.
  - RX_REG: assemble 4 bytes into o_reg_data. o_reg_we pulses the clock after the 4th byte, then o_reg_addr increments. After index 31, reset o_reg_addr to 0 and go to RX_MEM_ADDR.
  - RX_MEM_ADDR: a byte goes to o_mem_addr, then RX_MEM_DATA.
  - RX_MEM_DATA: assemble 4 bytes; pulse o_mem_we; back to RX_MEM_ADDR.
- Timeout:
  - The counter runs in every RX_* state, clears on each i_rx_done, and saturates.
  - Reaching TIMEOUT in RX_MEM_ADDR with 0 bytes pending is normal end: o_done pulse, go to READY.
  - Reaching TIMEOUT in any other RX state, or mid-record, gives o_error; the partial word is not written; go to READY.
- Ignored inputs:
  - i_rx_done in IDLE/READY/SEND_* is ignored.
  - i_tx_done outside a pending byte is ignored.
  - i_load/i_run while o_busy is ignored.
- o_busy = 1 in every state except IDLE/READY.

Test Plan:
- Reset low mid-SEND_INSTR -> all outputs 0 next clock; no further o_tx_start.
- i_load with n_instr=2, mode=4, ROM {0x11223344, 0xAABBCCDD} -> tx bytes 02,44,33,22,11,DD,CC,BB,AA,04; exactly 10 start pulses.
- Dump of PC=0x05, cycles=0x09, reg k = k*0x01010101, then idle TIMEOUT -> o_pc=05, o_cycles=09; 32 o_reg_we pulses; reg 31 data 0x1F1F1F1F; o_done 1 pulse; state READY.
- Two memory records (0x03, 0xDEADBEEF), (0x7F, 0x00000001) after registers -> 2 o_mem_we pulses with those values, then o_done.
- Silence after the 2nd byte of a memory word -> o_error pulse, no o_mem_we, state READY.
- Invalid commands: i_mode=8'd7, i_n_instr=0, and i_run in IDLE -> o_error pulse each, no tx. Then i_run in READY with mode 16 -> single byte 0x10 sent.
